// File: rtl/filter_svf_pipelined_pkg.sv
// Shared constants, FSM state type and saturation helper for the state-variable filter.
package svf_pkg;

  localparam int COEF_BITS  = 18;
  localparam int F_SHIFT    = 17;
  localparam int Q_SHIFT    = 16;
  localparam int GUARD_BITS = 4;
  // Wide enough to hold any sum of shifted products and state without overflow.
  localparam int CALC_BITS  = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_BAND,
    ST_OUT
  } svf_state_e;

  // Clamp a wide signed value into the signed range of the given bit width.
  function automatic logic signed [CALC_BITS-1:0] saturate(
    input logic signed [CALC_BITS-1:0] value,
    input int                          width
  );
    logic signed [CALC_BITS-1:0] max_v;
    logic signed [CALC_BITS-1:0] min_v;
    max_v = (48'sd1 <<< (width - 1)) - 48'sd1;
    min_v = -(48'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/filter_svf_pipelined_clock_divider.sv
// Free-running divider that derives a 50% duty sample strobe from the system clock.
module clock_divider #(
  parameter int DIVISOR = 2
) (
  input  logic cin,
  output logic cout
);

  localparam int HALF     = (DIVISOR / 2 > 0) ? DIVISOR / 2 : 1;
  localparam int CNT_BITS = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(HALF - 1);

  logic [CNT_BITS-1:0] count_q = '0;
  logic [CNT_BITS-1:0] count_d;
  logic                cout_q  = 1'b0;
  logic                cout_d;

  // Count half periods and flip the output at the end of each one.
  always_comb begin
    count_d = count_q + 1'b1;
    cout_d  = cout_q;
    if (count_q == LAST) begin
      count_d = '0;
      cout_d  = ~cout_q;
    end
  end

  // Divider state register; powers up with the output low.
  always_ff @(posedge cin) begin
    count_q <= count_d;
    cout_q  <= cout_d;
  end

  assign cout = cout_q;

endmodule

// File: rtl/filter_svf_pipelined.sv
// Chamberlin state-variable filter, one update per sample strobe edge, using a
// single time-shared signed multiplier over the LOW/HIGH/BAND cycles.
module filter_svf_pipelined
  import svf_pkg::*;
#(
  parameter int SAMPLE_BITS = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_clk,
  input  logic signed [SAMPLE_BITS-1:0] in,
  input  logic signed [COEF_BITS-1:0]   F,
  input  logic signed [COEF_BITS-1:0]   Q1,
  output logic signed [SAMPLE_BITS-1:0] out_highpass,
  output logic signed [SAMPLE_BITS-1:0] out_lowpass,
  output logic signed [SAMPLE_BITS-1:0] out_bandpass,
  output logic signed [SAMPLE_BITS-1:0] out_notch
);

  localparam int STATE_BITS = SAMPLE_BITS + GUARD_BITS;
  localparam int PROD_BITS  = COEF_BITS + STATE_BITS;

  svf_state_e                    state_q, state_d;
  logic                          prev_sc_q, prev_sc_d;
  logic signed [SAMPLE_BITS-1:0] in_q, in_d;
  logic signed [COEF_BITS-1:0]   f_q, f_d;
  logic signed [COEF_BITS-1:0]   q1_q, q1_d;
  logic signed [STATE_BITS-1:0]  low_q, low_d;
  logic signed [STATE_BITS-1:0]  band_q, band_d;
  logic signed [STATE_BITS-1:0]  high_q, high_d;
  logic signed [SAMPLE_BITS-1:0] out_hp_q, out_hp_d;
  logic signed [SAMPLE_BITS-1:0] out_lp_q, out_lp_d;
  logic signed [SAMPLE_BITS-1:0] out_bp_q, out_bp_d;
  logic signed [SAMPLE_BITS-1:0] out_notch_q, out_notch_d;

  logic                          start;
  logic signed [COEF_BITS-1:0]   mul_a;
  logic signed [STATE_BITS-1:0]  mul_b;
  logic signed [PROD_BITS-1:0]   product;
  logic signed [CALC_BITS-1:0]   prod_w;
  logic signed [CALC_BITS-1:0]   in_w;
  logic signed [CALC_BITS-1:0]   low_w;
  logic signed [CALC_BITS-1:0]   band_w;
  logic signed [CALC_BITS-1:0]   high_w;
  logic signed [CALC_BITS-1:0]   notch_w;

  // Route the coefficient and state operand for whichever term this cycle needs.
  always_comb begin
    mul_a = f_q;
    mul_b = band_q;
    case (state_q)
      ST_HIGH: begin
        mul_a = q1_q;
        mul_b = band_q;
      end
      ST_BAND: begin
        mul_a = f_q;
        mul_b = high_q;
      end
      default: begin
        mul_a = f_q;
        mul_b = band_q;
      end
    endcase
    product = mul_a * mul_b;
    prod_w  = {{(CALC_BITS - PROD_BITS){product[PROD_BITS-1]}}, product};
    in_w    = CALC_BITS'(in_q);
    low_w   = CALC_BITS'(low_q);
    band_w  = CALC_BITS'(band_q);
    high_w  = CALC_BITS'(high_q);
  end

  // Sequence one filter update per strobe edge; low_q already holds the new low by HIGH.
  always_comb begin
    state_d     = state_q;
    prev_sc_d   = sample_clk;
    in_d        = in_q;
    f_d         = f_q;
    q1_d        = q1_q;
    low_d       = low_q;
    band_d      = band_q;
    high_d      = high_q;
    out_hp_d    = out_hp_q;
    out_lp_d    = out_lp_q;
    out_bp_d    = out_bp_q;
    out_notch_d = out_notch_q;
    notch_w     = '0;
    start       = sample_clk & ~prev_sc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          in_d    = in;
          f_d     = F;
          q1_d    = Q1;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        low_d   = STATE_BITS'(saturate(low_w + (prod_w >>> F_SHIFT), STATE_BITS));
        state_d = ST_HIGH;
      end
      ST_HIGH: begin
        high_d  = STATE_BITS'(saturate(in_w - low_w - (prod_w >>> Q_SHIFT), STATE_BITS));
        state_d = ST_BAND;
      end
      ST_BAND: begin
        band_d  = STATE_BITS'(saturate(band_w + (prod_w >>> F_SHIFT), STATE_BITS));
        state_d = ST_OUT;
      end
      ST_OUT: begin
        notch_w     = saturate(high_w + low_w, STATE_BITS);
        out_hp_d    = SAMPLE_BITS'(saturate(high_w, SAMPLE_BITS));
        out_lp_d    = SAMPLE_BITS'(saturate(low_w, SAMPLE_BITS));
        out_bp_d    = SAMPLE_BITS'(saturate(band_w, SAMPLE_BITS));
        out_notch_d = SAMPLE_BITS'(saturate(notch_w, SAMPLE_BITS));
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous clear that also aborts an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      prev_sc_q   <= 1'b0;
      in_q        <= '0;
      f_q         <= '0;
      q1_q        <= '0;
      low_q       <= '0;
      band_q      <= '0;
      high_q      <= '0;
      out_hp_q    <= '0;
      out_lp_q    <= '0;
      out_bp_q    <= '0;
      out_notch_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_sc_q   <= prev_sc_d;
      in_q        <= in_d;
      f_q         <= f_d;
      q1_q        <= q1_d;
      low_q       <= low_d;
      band_q      <= band_d;
      high_q      <= high_d;
      out_hp_q    <= out_hp_d;
      out_lp_q    <= out_lp_d;
      out_bp_q    <= out_bp_d;
      out_notch_q <= out_notch_d;
    end
  end

  assign out_highpass = out_hp_q;
  assign out_lowpass  = out_lp_q;
  assign out_bandpass = out_bp_q;
  assign out_notch    = out_notch_q;

endmodule

// File: tb/tb_filter_svf_pipelined.sv
// Directed bench for the state-variable filter with hand-computed expected outputs.
module tb_filter_svf_pipelined;

  localparam logic signed [11:0] S_MAX = 12'h7FF;
  localparam logic signed [11:0] S_MIN = 12'h800;

  logic               clk;
  logic               rst;
  logic               manual_sc;
  logic               use_div16;
  logic               use_square;
  logic               div16;
  logic               div1024;
  logic               sample_clk;
  logic signed [11:0] manual_in;
  logic signed [11:0] in_mux;
  logic signed [17:0] coef_f;
  logic signed [17:0] coef_q1;
  logic signed [11:0] out_hp;
  logic signed [11:0] out_lp;
  logic signed [11:0] out_bp;
  logic signed [11:0] out_nt;

  int pass_checks  = 0;
  int total_checks = 0;

  clock_divider #(.DIVISOR(16)) u_div16 (
    .cin  (clk),
    .cout (div16)
  );

  clock_divider #(.DIVISOR(1024)) u_div1024 (
    .cin  (clk),
    .cout (div1024)
  );

  assign sample_clk = use_div16 ? div16 : manual_sc;
  assign in_mux     = use_square ? (div1024 ? S_MAX : S_MIN) : manual_in;

  filter_svf_pipelined #(.SAMPLE_BITS(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_clk   (sample_clk),
    .in           (in_mux),
    .F            (coef_f),
    .Q1           (coef_q1),
    .out_highpass (out_hp),
    .out_lowpass  (out_lp),
    .out_bandpass (out_bp),
    .out_notch    (out_nt)
  );

  // Free-running 10-unit system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_checks++;
    assert (observed === expected) pass_checks++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic checkAll(input string tag, input int hp, input int lp, input int bp, input int nt);
    checkOutput({tag, "_hp"}, int'(out_hp), hp);
    checkOutput({tag, "_lp"}, int'(out_lp), lp);
    checkOutput({tag, "_bp"}, int'(out_bp), bp);
    checkOutput({tag, "_notch"}, int'(out_nt), nt);
  endtask

  task automatic applyStimulus(input int in_v, input int f_v, input int q1_v);
    manual_in = 12'(in_v);
    coef_f    = 18'(f_v);
    coef_q1   = 18'(q1_v);
  endtask

  // Called at a negedge; returns at the negedge after the outputs load (edge k+4).
  task automatic runUpdate();
    manual_sc = 1'b1;
    @(negedge clk);
    manual_sc = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic doReset();
    manual_sc = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int bad_range;
    int changes;
    logic signed [11:0] last_hp;

    rst        = 1'b0;
    manual_sc  = 1'b0;
    use_div16  = 1'b0;
    use_square = 1'b0;
    applyStimulus(123, 777, -55);
    @(negedge clk);

    // Reset with arbitrary inputs clears all outputs.
    rst = 1'b1;
    @(negedge clk);
    checkAll("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // First update: latency of four edges, inputs changed mid-update are ignored.
    applyStimulus(1000, 52428, 16384);
    manual_sc = 1'b1;
    @(negedge clk);
    manual_sc = 1'b0;
    applyStimulus(-555, 0, 0);
    repeat (3) @(negedge clk);
    checkOutput("latency_hp_k3", int'(out_hp), 0);
    checkOutput("latency_bp_k3", int'(out_bp), 0);
    @(negedge clk);
    checkAll("step1", 1000, 0, 399, 1000);

    applyStimulus(1000, 52428, 16384);
    runUpdate();
    checkAll("step2", 742, 159, 695, 901);
    runUpdate();
    checkAll("step3", 391, 436, 851, 827);

    // Reset mid-update aborts it and clears state.
    manual_sc = 1'b1;
    @(negedge clk);
    manual_sc = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkAll("midreset", 0, 0, 0, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("midreset_idle_hp", int'(out_hp), 0);
    applyStimulus(-1000, 52428, 16384);
    runUpdate();
    checkAll("negstep", -1000, 0, -400, -1000);

    // Positive overdrive: F near 1.0, Q1 = -2.0 forces growth into saturation.
    doReset();
    applyStimulus(2047, 131071, -131072);
    runUpdate();
    checkAll("satp1", 2047, 0, 2046, 2047);
    runUpdate();
    checkAll("satp2", 2047, 2045, 2047, 2047);
    runUpdate();
    checkAll("satp3", 2047, 2047, 2047, 2047);
    repeat (3) runUpdate();
    checkAll("satp6", 2047, 2047, 2047, 2047);

    // Negative extreme input rounds toward minus infinity and clamps low.
    doReset();
    applyStimulus(-2048, 131071, 0);
    runUpdate();
    checkAll("satn1", -2048, 0, -2048, -2048);
    runUpdate();
    checkAll("satn2", 0, -2048, -2048, -2048);

    // Strobe held high for 100 cycles gives exactly one update.
    doReset();
    applyStimulus(1000, 52428, 16384);
    manual_sc = 1'b1;
    repeat (100) @(negedge clk);
    manual_sc = 1'b0;
    repeat (6) @(negedge clk);
    checkAll("hold", 1000, 0, 399, 1000);

    // Strobe toggling every 2 cycles: only every other edge is accepted.
    doReset();
    for (int i = 0; i < 6; i++) begin
      manual_sc = 1'b1;
      repeat (2) @(negedge clk);
      manual_sc = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checkAll("abuse", 391, 436, 851, 827);

    // DC convergence with the divided strobe.
    doReset();
    applyStimulus(1000, 52428, 16384);
    use_div16 = 1'b1;
    repeat (32100) @(negedge clk);
    checkOutput("dc_lp", int'(out_lp >= 998 && out_lp <= 1002), 1);
    checkOutput("dc_hp", int'(out_hp >= -2 && out_hp <= 2), 1);
    checkOutput("dc_bp", int'(out_bp >= -2 && out_bp <= 2), 1);

    // Full-scale square wave into a high-Q filter.
    doReset();
    applyStimulus(0, 52428, 1024);
    use_square = 1'b1;
    bad_range  = 0;
    changes    = 0;
    last_hp    = out_hp;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_hp > S_MAX || out_hp < S_MIN || out_lp > S_MAX || out_lp < S_MIN ||
          out_bp > S_MAX || out_bp < S_MIN || out_nt > S_MAX || out_nt < S_MIN ||
          $isunknown({out_hp, out_lp, out_bp, out_nt})) begin
        bad_range++;
      end
      if (out_hp !== last_hp) changes++;
      last_hp = out_hp;
    end
    checkOutput("square_range", bad_range, 0);
    checkOutput("square_active", int'(changes > 10), 1);
    use_square = 1'b0;
    use_div16  = 1'b0;

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/filter_svf_pipelined.md
# filter_svf_pipelined

Chamberlin state-variable filter (SVF) for the synth voice path. Each rising edge of a sample strobe starts one filter update. The update is computed over several fast-clock cycles with a single time-shared multiplier. It produces simultaneous high-pass, low-pass, band-pass and notch outputs. Cutoff (`F`) and resonance (`Q1`) are run-time inputs, so an envelope or LFO can modulate them per sample.

## Interface
- `SAMPLE_BITS`, default 12: width of the audio input and all outputs (signed).
- `clk` input 1: system clock; all logic runs on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `sample_clk` input 1: sample strobe.
  - Level signal in the `clk` domain; a rising edge requests one update.
  - Edge detection happens inside the block.
- `in` input `SAMPLE_BITS`: signed audio sample.
- `F` input 18: signed cutoff coefficient, fixed point 1.17 (2^17 = 1.0); F = 2·sin(π·fc/fs).
- `Q1` input 18: signed damping coefficient, fixed point 2.16 (2^16 = 1.0); Q1 = 1/Q.
- `out_highpass`, `out_lowpass`, `out_bandpass`, `out_notch` output `SAMPLE_BITS` each: signed registered filter outputs.

## Operation
- State: `low` and `band`, signed, `SAMPLE_BITS+4` bits each (4 guard bits).
- Per sample, in order:
  - low ← sat(low + (F·band)>>>17)
  - high ← sat(in − low_new − (Q1·band)>>>16)
  - band ← sat(band + (F·high)>>>17)
  - notch ← sat(high + low_new)
- Products are full-width signed. Shifts are arithmetic, so results round toward −∞.
- Internal results saturate to the `SAMPLE_BITS+4` range. Outputs saturate to [−2^(SAMPLE_BITS−1), 2^(SAMPLE_BITS−1)−1]. Nothing wraps.
- Edge detect: a register holds the previous `sample_clk`. A start is `sample_clk`=1 with previous=0.
- At start, `in`, `F` and `Q1` are latched. Later changes to these inputs do not affect the update in progress.
- FSM states and transitions:
  - IDLE → LOW (start: latch inputs)
  - LOW → HIGH (compute low)
  - HIGH → BAND (compute high)
  - BAND → OUT (compute band)
  - OUT → IDLE (compute notch, load all four output registers)
- A start edge that arrives while the FSM is not in IDLE is ignored and is not queued.
- `sample_clk` held high gives exactly one update.
- Reset clears `low`, `band`, the high/notch temporaries, all outputs and the previous-strobe register to 0, and returns the FSM to IDLE. Reset mid-update aborts the update.

## Timing
- Start detected at clk edge k.
- All four outputs update together at edge k+4 and hold until the next update.
- Minimum strobe period is 5 clk cycles. Shorter periods drop samples as described above.
- There are no other handshakes.

## Structure
- Shared package `svf_pkg`:
  - coefficient widths (18)
  - fractional shifts (`F_SHIFT`=17, `Q_SHIFT`=16)
  - guard-bit count (4)
  - a saturate function parameterised by target width
- One natural sub-module: `clock_divider`, used by system and bench to derive `sample_clk`.
  - Parameter `DIVISOR`.
  - Ports: `cin` (input), `cout` (output).
  - `cout` toggles every `DIVISOR`/2 `cin` cycles, giving a period of `DIVISOR` cycles and 50% duty.
  - `cout` starts at 0.
- The filter itself contains one 18×16 signed multiplier, multiplexed across the LOW/HIGH/BAND states.

## Test plan
- Reset: assert `rst` with any inputs → all four outputs 0 on the next clock, and FSM in IDLE.
- Single step from zero state, `in`=1000, `F`=52428, `Q1`=16384, one strobe → four cycles later hp=1000, lp=0, bp=399, notch=1000.
- Second strobe, same inputs → hp=742, lp=159, bp=695, notch=901.
- DC convergence: `in`=1000 held for 2000 strobes, with `sample_clk` from `clock_divider` `DIVISOR`=16 → lp within 1000±2; hp and bp within ±2.
- Saturation: square wave ±2047/−2048 from `clock_divider` `DIVISOR`=1024, `F`=52428 (0.4), `Q1`=1024 (Q=64), over 1000 clk → every output stays within [−2048, 2047] with no sign flips from wrap.
- Strobe abuse: toggle `sample_clk` every 2 clk cycles → updates occur at most every 5 cycles. Separately, hold `sample_clk` high for 100 cycles → exactly one update.
